// File: rtl/ulbf_slave_rx_ctrl.sv
// ULBF slave RX capture sequencer: writes AXI4-Stream beats into RX RAM port A, counts
// TLAST-delimited iterations and raises rxdone. Optional length check: ULBF_RX_LEN_CHECK_EN.
module ulbf_slave_rx_ctrl #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned FRAME_LEN = 256
) (
    input  logic              s_axis_clk,
    input  logic              slave_rst_saxis,
    input  logic [11:0]       niter_saxis,
    input  logic [63:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [63:0]       ram_dina,
    output logic              rxdone_saxis,
    output logic [3:0]        current_state_saxis,
    output logic [15:0]       rxram_counter_saxis,
    output logic              len_err
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] LastSlot = {1'b0, {ADDR_W{1'b1}}};

    if (ADDR_W == 0 || ADDR_W > 16 || FRAME_LEN == 0) begin : g_bad_param
        $error("ulbf_slave_rx_ctrl: unsupported ADDR_W or FRAME_LEN");
    end

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StArm      = 4'd1,
        StCapture  = 4'd2,
        StDone     = 4'd3,
        StOverflow = 4'd4
    } state_e;

    state_e            state_q, state_d;
    logic [11:0]       niter_prev_q, niter_prev_d;
    logic [11:0]       n_lat_q, n_lat_d;
    logic [11:0]       iter_cnt_q, iter_cnt_d;
    logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
    logic              ram_ena_q, ram_ena_d;
    logic [ADDR_W-1:0] ram_addra_q, ram_addra_d;
    logic [63:0]       ram_dina_q, ram_dina_d;

    logic        hs;
    logic        arm_ok;
    logic        final_beat;
    logic        last_slot;
    logic [16:0] cnt_ext;

    assign hs         = s_axis_tvalid & s_axis_tready;
    assign arm_ok     = (niter_saxis != 12'd0) && (niter_saxis == niter_prev_q);
    assign final_beat = s_axis_tlast && ((iter_cnt_q + 12'd1) == n_lat_q);
    assign last_slot  = (beat_cnt_q == LastSlot);

    // State register
    always_ff @(posedge s_axis_clk) begin
        if (slave_rst_saxis) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a final tlast on the last slot wins over overflow
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (arm_ok) begin
                    state_d = StArm;
                end
            end
            StArm, StCapture: begin
                if (hs) begin
                    if (final_beat) begin
                        state_d = StDone;
                    end else if (last_slot) begin
                        state_d = StOverflow;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StDone:     state_d = StDone;
            StOverflow: state_d = StOverflow;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        s_axis_tready       = (state_q == StArm) || (state_q == StCapture);
        rxdone_saxis        = (state_q == StDone);
        current_state_saxis = state_q;
    end

    always_comb begin
        niter_prev_d = niter_saxis;
        n_lat_d      = n_lat_q;
        iter_cnt_d   = iter_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        ram_ena_d    = hs;
        ram_addra_d  = ram_addra_q;
        ram_dina_d   = ram_dina_q;
        if (state_q == StIdle && arm_ok) begin
            n_lat_d = niter_saxis;
        end
        if (hs) begin
            // hs cannot occur past LastSlot, so the beat count never wraps
            beat_cnt_d  = beat_cnt_q + 1'b1;
            ram_addra_d = beat_cnt_q[ADDR_W-1:0];
            ram_dina_d  = s_axis_tdata;
            if (s_axis_tlast) begin
                iter_cnt_d = iter_cnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge s_axis_clk) begin
        if (slave_rst_saxis) begin
            niter_prev_q <= 12'd0;
            n_lat_q      <= 12'd0;
            iter_cnt_q   <= 12'd0;
            beat_cnt_q   <= '0;
            ram_ena_q    <= 1'b0;
            ram_addra_q  <= '0;
            ram_dina_q   <= 64'd0;
        end else begin
            niter_prev_q <= niter_prev_d;
            n_lat_q      <= n_lat_d;
            iter_cnt_q   <= iter_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            ram_ena_q    <= ram_ena_d;
            ram_addra_q  <= ram_addra_d;
            ram_dina_q   <= ram_dina_d;
        end
    end

    assign ram_ena   = ram_ena_q;
    assign ram_wea   = ram_ena_q;
    assign ram_addra = ram_addra_q;
    assign ram_dina  = ram_dina_q;

    // A full 2**16 RAM would not fit 16 bits; saturate rather than show zero
    assign cnt_ext             = 17'(beat_cnt_q);
    assign rxram_counter_saxis = cnt_ext[16] ? 16'hFFFF : cnt_ext[15:0];

`ifdef ULBF_RX_LEN_CHECK_EN
    localparam logic [16:0] FrameLen = 17'(FRAME_LEN);

    logic [16:0] fbeat_q, fbeat_d;
    logic [16:0] fbeat_inc;
    logic        len_err_q, len_err_d;

    always_comb begin
        fbeat_inc = fbeat_q + 17'd1;
        fbeat_d   = fbeat_q;
        len_err_d = len_err_q;
        if (hs) begin
            if (s_axis_tlast) begin
                fbeat_d = 17'd0;
                if (fbeat_inc != FrameLen) begin
                    len_err_d = 1'b1;
                end
            end else begin
                fbeat_d = fbeat_inc;
                if (fbeat_inc >= FrameLen) begin
                    len_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s_axis_clk) begin
        if (slave_rst_saxis) begin
            fbeat_q   <= 17'd0;
            len_err_q <= 1'b0;
        end else begin
            fbeat_q   <= fbeat_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_ulbf_slave_rx_ctrl.sv
// Bench for ulbf_slave_rx_ctrl: vector table, corner-case sequences and random traffic
// checked every cycle against a beat/iteration-level reference model.
module tb_ulbf_slave_rx_ctrl;

    localparam int unsigned AW    = 3;
    localparam int          FL    = 4;
    localparam int          DEPTH = 8;
`ifdef ULBF_RX_LEN_CHECK_EN
    localparam bit LenChk = 1'b1;
`else
    localparam bit LenChk = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [11:0]   niter;
    logic [63:0]   tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [63:0]   dina;
    logic          rxdone;
    logic [3:0]    cur_state;
    logic [15:0]   cnt;
    logic          len_err;

    always #5 clk = ~clk;

    ulbf_slave_rx_ctrl #(
        .ADDR_W   (AW),
        .FRAME_LEN(FL)
    ) dut (
        .s_axis_clk         (clk),
        .slave_rst_saxis    (rst),
        .niter_saxis        (niter),
        .s_axis_tdata       (tdata),
        .s_axis_tvalid      (tvalid),
        .s_axis_tlast       (tlast),
        .s_axis_tready      (tready),
        .ram_ena            (ena),
        .ram_wea            (wea),
        .ram_addra          (addra),
        .ram_dina           (dina),
        .rxdone_saxis       (rxdone),
        .current_state_saxis(cur_state),
        .rxram_counter_saxis(cnt),
        .len_err            (len_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase 0 idle, 1 armed, 2 capturing, 3 done, 4 overflow
    int          m_state, m_count, m_iters, m_nlat, m_prev, m_fbeats, m_addr;
    bit          m_we, m_len_err;
    logic [63:0] m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = 0; m_count = 0; m_iters = 0; m_nlat = 0; m_prev = 0;
            m_fbeats = 0; m_we = 1'b0; m_len_err = 1'b0; m_addr = 0; m_data = 64'd0;
        end else begin
            m_we = 1'b0;
            if (m_state == 0) begin
                if (niter != 0 && int'(niter) == m_prev) begin
                    m_nlat  = int'(niter);
                    m_state = 1;
                end
            end else if ((m_state == 1 || m_state == 2) && tvalid) begin
                m_we   = 1'b1;
                m_addr = m_count;
                m_data = tdata;
                m_count++;
                m_fbeats++;
                if (LenChk && (tlast ? (m_fbeats != FL) : (m_fbeats >= FL))) m_len_err = 1'b1;
                if (tlast) begin
                    m_iters++;
                    m_fbeats = 0;
                end
                if (tlast && m_iters == m_nlat) m_state = 3;
                else if (m_count == DEPTH)      m_state = 4;
                else                            m_state = 2;
            end
            m_prev = int'(niter);
        end
    endtask

    task automatic check_outputs();
        chk("state", 64'(cur_state), 64'(m_state));
        chk("tready", 64'(tready), 64'(m_state == 1 || m_state == 2));
        chk("rxdone", 64'(rxdone), 64'(m_state == 3));
        chk("counter", 64'(cnt), 64'(m_count));
        chk("ram_ena", 64'(ena), 64'(m_we));
        chk("ram_wea", 64'(wea), 64'(m_we));
        if (m_we) begin
            chk("ram_addra", 64'(addra), 64'(m_addr));
            chk("ram_dina", dina, m_data);
        end
        chk("len_err", 64'(len_err), 64'(m_len_err));
    endtask

    // Inputs are driven at the falling edge; outputs are checked at the next falling edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; niter = 12'd0; tdata = 64'd0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic arm(input int n);
        niter = 12'(n);
        cycle();
        cycle();
    endtask

    task automatic send_frame(input int len, input logic [63:0] base);
        for (int i = 0; i < len; i++) begin
            tvalid = 1'b1;
            tdata  = base + 64'(i);
            tlast  = (i == len - 1);
            cycle();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        logic [11:0] niter;
        bit          tv;
        bit          tl;
        logic [63:0] d;
        int          st;
        bit          rdy;
        bit          ena;
        int          addr;
        int          cnt;
        bit          done;
    } vec_t;

    vec_t tbl[13];

    task automatic set_vec(input int i, input bit r, input int n, input bit tv, input bit tl,
                           input int k, input int st, input bit rdy, input bit en,
                           input int addr, input int c, input bit dn);
        tbl[i].rst = r;  tbl[i].niter = 12'(n); tbl[i].tv = tv;    tbl[i].tl = tl;
        tbl[i].d   = 64'hD000_0000_0000_0000 + 64'(k);
        tbl[i].st  = st; tbl[i].rdy = rdy; tbl[i].ena = en; tbl[i].addr = addr;
        tbl[i].cnt = c;  tbl[i].done = dn;
    endtask

    initial begin
        rst = 1'b1; niter = 12'd0; tdata = 64'd0; tvalid = 1'b0; tlast = 1'b0;

        // niter=2, two 4-beat frames, then tvalid in DONE must be ignored
        //         rst n  tv tl k   st rdy en addr cnt done
        set_vec(0,  1, 0, 0, 0, 0,  0, 0,  0, 0,   0,  0);
        set_vec(1,  0, 2, 0, 0, 0,  0, 0,  0, 0,   0,  0);
        set_vec(2,  0, 2, 0, 0, 0,  1, 1,  0, 0,   0,  0);
        set_vec(3,  0, 2, 1, 0, 0,  2, 1,  1, 0,   1,  0);
        set_vec(4,  0, 2, 1, 0, 1,  2, 1,  1, 1,   2,  0);
        set_vec(5,  0, 2, 1, 0, 2,  2, 1,  1, 2,   3,  0);
        set_vec(6,  0, 2, 1, 1, 3,  2, 1,  1, 3,   4,  0);
        set_vec(7,  0, 2, 0, 0, 9,  2, 1,  0, 0,   4,  0);
        set_vec(8,  0, 2, 1, 0, 4,  2, 1,  1, 4,   5,  0);
        set_vec(9,  0, 2, 1, 0, 5,  2, 1,  1, 5,   6,  0);
        set_vec(10, 0, 2, 1, 0, 6,  2, 1,  1, 6,   7,  0);
        set_vec(11, 0, 2, 1, 1, 7,  3, 0,  1, 7,   8,  1);
        set_vec(12, 0, 2, 1, 0, 8,  3, 0,  0, 0,   8,  1);

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; niter = tbl[i].niter; tvalid = tbl[i].tv;
            tlast = tbl[i].tl; tdata = tbl[i].d;
            cycle();
            chk($sformatf("tbl%0d_state", i), 64'(cur_state), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_tready", i), 64'(tready), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_ena", i), 64'(ena), 64'(tbl[i].ena));
            chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_rxdone", i), 64'(rxdone), 64'(tbl[i].done));
            if (tbl[i].ena) begin
                chk($sformatf("tbl%0d_addr", i), 64'(addra), 64'(tbl[i].addr));
                chk($sformatf("tbl%0d_dina", i), dina, tbl[i].d);
            end
        end
        chk("tbl_len_err", 64'(len_err), 64'(0));

        // niter glitches 0->5->3, arms only on two equal samples, then ignores niter
        do_reset();
        niter = 12'd5; cycle();
        niter = 12'd3; cycle();
        chk("t2_not_armed", 64'(cur_state), 64'(0));
        cycle();
        chk("t2_armed", 64'(cur_state), 64'(1));
        niter = 12'd7;
        send_frame(2, 64'h100);
        send_frame(2, 64'h200);
        chk("t2_after_two", 64'(cur_state), 64'(2));
        send_frame(2, 64'h300);
        chk("t2_done", 64'(cur_state), 64'(3));

        // 9-beat frame into an 8-deep RAM overflows after beat 7
        do_reset();
        arm(1);
        send_frame(9, 64'h400);
        chk("t3_state", 64'(cur_state), 64'(4));
        chk("t3_cnt", 64'(cnt), 64'(8));
        chk("t3_tready", 64'(tready), 64'(0));
        chk("t3_rxdone", 64'(rxdone), 64'(0));

        // final tlast exactly on the last slot completes instead of overflowing
        do_reset();
        arm(1);
        send_frame(8, 64'h500);
        chk("t4_state", 64'(cur_state), 64'(3));
        chk("t4_cnt", 64'(cnt), 64'(8));

        // reset mid-frame, then a full re-armed capture
        do_reset();
        arm(1);
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1; tdata = 64'h600 + 64'(i); cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0; tvalid = 1'b0;
        chk("t5_state", 64'(cur_state), 64'(0));
        chk("t5_cnt", 64'(cnt), 64'(0));
        chk("t5_tready", 64'(tready), 64'(0));
        chk("t5_ena", 64'(ena), 64'(0));
        arm(2);
        send_frame(4, 64'h700);
        send_frame(4, 64'h800);
        chk("t5_rearm_done", 64'(cur_state), 64'(3));
        chk("t5_rearm_cnt", 64'(cnt), 64'(8));

        // frames of 4 and 3 beats: length error only with the check built in
        do_reset();
        arm(2);
        send_frame(4, 64'h900);
        chk("t6_len_ok", 64'(len_err), 64'(0));
        send_frame(3, 64'hA00);
        chk("t6_len_err", 64'(len_err), 64'(LenChk));
        chk("t6_done", 64'(cur_state), 64'(3));

        // random traffic, occasional niter noise and resets
        for (int r = 0; r < 60; r++) begin
            int n;
            do_reset();
            n = int'($urandom_range(1, 3));
            niter = 12'($urandom_range(0, 4095));
            cycle();
            arm(n);
            for (int c = 0; c < 40; c++) begin
                tvalid = ($urandom_range(0, 3) != 0);
                tlast  = ($urandom_range(0, 3) == 0);
                tdata  = {$urandom(), $urandom()};
                niter  = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095)) : 12'(n);
                rst    = ($urandom_range(0, 99) == 0);
                cycle();
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
